// File: rtl/vec_loader.sv
`default_nettype none
// ============================================================================
// Module      : vec_loader
// Description : Packs a narrow valid/ready word stream into full vectors and
//               issues one buffer write per completed vector. A job writes
//               i_num_vec consecutive entries from i_base_addr (wrapping) and
//               ends with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_loader #(
    parameter int VEC_WIDTH  = 384,
    parameter int IN_WIDTH   = 32,
    parameter int ARR_DEPTH  = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_num_vec,
    input  logic                  i_valid,
    input  logic [IN_WIDTH-1:0]   i_data,
    output logic                  o_ready,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr_wr,
    output logic [VEC_WIDTH-1:0]  o_data_wr,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int WPV    = VEC_WIDTH / IN_WIDTH;
    localparam int WCNT_W = (WPV > 1) ? $clog2(WPV) : 1;

    localparam logic [WCNT_W-1:0]   c_LAST_WORD = WCNT_W'(WPV - 1);
    localparam logic [ADDR_WIDTH:0] c_VEC_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] c_DEPTH     = (ADDR_WIDTH + 1)'(ARR_DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOAD = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_count;
    logic [WCNT_W-1:0]     r_word_cnt;
    logic [ADDR_WIDTH:0]   r_vec_idx;

    // Holds only the newest WPV-1 words: the oldest word of a full-width
    // shifter would be shifted out before it is ever read, so it is not kept.
    // The completed vector is this register with the final word on top.
    logic [VEC_WIDTH-IN_WIDTH-1:0] r_sh;
    logic [VEC_WIDTH-1:0]          w_vec_full;

    logic                  w_accept;
    logic                  w_vec_done;
    logic                  w_last;
    logic                  w_zero_start;
    logic [ADDR_WIDTH:0]   w_addr_sum;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_accept     = i_valid && (r_state == S_LOAD);
    assign w_vec_done   = w_accept && (r_word_cnt == c_LAST_WORD);
    assign w_last       = w_vec_done && (r_vec_idx == (r_count - c_VEC_ONE));
    assign w_zero_start = (r_state == S_IDLE) && i_start && (i_num_vec == '0);
    assign w_vec_full   = {i_data, r_sh};

    // Write address: base plus vector index, wrapped to the buffer depth.
    assign w_addr_sum = {1'b0, r_base} + {1'b0, r_vec_idx[ADDR_WIDTH-1:0]};
    assign w_addr     = ADDR_WIDTH'(w_addr_sum % c_DEPTH);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: enter LOAD on a non-empty start, leave after last vector.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start && (i_num_vec != '0)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs: ready and busy depend on state only.
    always_comb begin
        o_ready = 1'b0;
        o_busy  = 1'b0;
        if (r_state == S_LOAD) begin
            o_ready = 1'b1;
            o_busy  = 1'b1;
        end
    end

    // Job parameters, word/vector counters and packing shifter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base     <= '0;
            r_count    <= '0;
            r_word_cnt <= '0;
            r_vec_idx  <= '0;
            r_sh       <= '0;
        end else if (r_state == S_IDLE) begin
            if (i_start) begin
                r_base     <= i_base_addr;
                r_count    <= i_num_vec;
                r_word_cnt <= '0;
                r_vec_idx  <= '0;
                r_sh       <= '0;
            end
        end else if (w_accept) begin
            r_sh <= w_vec_full[VEC_WIDTH-1:IN_WIDTH];
            if (r_word_cnt == c_LAST_WORD) begin
                r_word_cnt <= '0;
                r_vec_idx  <= r_vec_idx + c_VEC_ONE;
            end else begin
                r_word_cnt <= r_word_cnt + WCNT_W'(1);
            end
        end
    end

    // Registered write port and done pulse; address/data hold between writes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_we      <= 1'b0;
            o_addr_wr <= '0;
            o_data_wr <= '0;
            o_done    <= 1'b0;
        end else begin
            o_we   <= w_vec_done;
            o_done <= w_last || w_zero_start;
            if (w_vec_done) begin
                o_addr_wr <= w_addr;
                o_data_wr <= w_vec_full;
            end
        end
    end

endmodule
`default_nettype wire
